design04_client: RTL and testbench
==================================

# design04_client

Requester-side driver for the `mkDesign_04` method interface: `start(a,b)` action, `result` value method, `check` actionvalue method. It accepts operand pairs from a host-side valid/ready port and sequences the three methods on the device while obeying each `RDY_*` guard. It returns the captured result/check pair, with a timeout flag, on a host-side response port. It sits between a test/host sequencer and the design instance, replacing hand-wired constant enables.

## Interface
- `WIDTH`, 8: operand/result width.
- `TIMEOUT`, 255: maximum cycles to wait on any single `RDY_*` guard (1..65535).
- `CLK` in 1: sole clock, rising edge.
- `RST_N` in 1: reset, synchronous, active-low.
- `req_valid` in 1: host request valid.
- `req_a` in WIDTH: operand a.
- `req_b` in WIDTH: operand b.
- `req_ready` out 1: client can accept a request.
- `rsp_valid` out 1: response available.
- `rsp_result` out WIDTH: captured `result`.
- `rsp_check` out WIDTH: captured `check`.
- `rsp_timeout` out 1: a guard wait exceeded `TIMEOUT`.
- `rsp_ready` in 1: host accepts response.
- `start_a` out WIDTH: to device `start_a`.
- `start_b` out WIDTH: to device `start_b`.
- `EN_start` out 1: to device `EN_start`.
- `RDY_start` in 1: from device.
- `result` in WIDTH: from device `resresult_`.
- `RDY_result` in 1: from device.
- `EN_check` out 1: to device `EN_check`.
- `check` in WIDTH: from device `chresult_`.
- `RDY_check` in 1: from device.
- `txn_count` out 16: completed transactions, including timeouts.

## Operation
FSM states: IDLE, START, WAIT_RES, CHECK, RESP.
- IDLE: `req_ready=1`. On `req_valid`, latch a/b into registers, clear the wait counter, and go to START.
- START: `start_a`/`start_b` are driven from the latched registers. `EN_start = (state==START) & RDY_start`; this combinational path from RDY to EN matches BSV method semantics. The cycle `EN_start` is asserted, go to WAIT_RES.
- WAIT_RES: when `RDY_result=1`, capture `result` and go to CHECK. `result` is never sampled while `RDY_result=0`.
- CHECK: `EN_check = (state==CHECK) & RDY_check`. In the same cycle, capture `check` (actionvalue returns its value in the enable cycle), then go to RESP.
- RESP: `rsp_valid=1` and the response outputs are stable. On `rsp_ready`, increment `txn_count` (wraps 0xFFFF→0) and go to IDLE.
- Timeout: in START, WAIT_RES and CHECK the wait counter increments every cycle the guard is low. When the counter equals `TIMEOUT` and the guard is still low, go to RESP with `rsp_timeout=1`. On a timeout, not-yet-captured fields read 0, and no EN is asserted in that cycle. The counter clears on every state change.
- Simultaneous events: a guard going high in the same cycle the counter reaches `TIMEOUT` counts as success, not timeout.
- `start_a`/`start_b` are zero outside START.

## Timing
- Reset (`RST_N=0` at a rising edge): state=IDLE. All registered outputs are 0: `rsp_*`, `txn_count`, latched operands, captures. `EN_start`/`EN_check` are 0 because they are gated by state. `req_ready` is 1 after reset.
- Reset mid-transaction aborts without a response. No EN is asserted in the reset cycle.
- Best-case latency with all RDY high: request accepted at cycle 0; START with `EN_start` at cycle 1; WAIT_RES captures at cycle 2; CHECK with `EN_check` at cycle 3; `rsp_valid` at cycle 4. Each guard stall adds 1 cycle per low cycle.
- `EN_start`/`EN_check` are pulses of exactly one cycle per transaction; at most one of the two is asserted in any cycle.
- One transaction in flight. `req_ready=0` from acceptance until the RESP handshake completes; the next request can be accepted the cycle after returning to IDLE.

## Structure
- Shared package `design04_pkg`: state enum `d04_state_t`, `D04_WIDTH=8`, `D04_CNT_W=16`.
- No sub-module needed. Optionally factor the wait counter as `guard_timer` (clear, enable, expire=count==TIMEOUT).

## Test plan
- All RDY tied 1; request a=0x12, b=0x34; device returns result=0x46, check=0xA5. Required: `EN_start` in cycle 1, `EN_check` in cycle 3, `rsp_valid` in cycle 4 with 0x46/0xA5/timeout=0, `txn_count=1`.
- `RDY_start` low for 5 cycles. Required: `EN_start` fires in the first cycle `RDY_start=1`, and never before; `start_a=0x12` during START.
- `RDY_result` stuck 0, `TIMEOUT=4`. Required: `rsp_timeout=1` and `rsp_result=0`, `EN_check` never asserted, `txn_count` increments after the handshake.
- `rsp_ready` held low 10 cycles. Required: `rsp_*` stable, `req_ready=0`, and a second `req_valid` is not accepted until the cycle after the handshake.
- `RST_N` pulled low during WAIT_RES. Required: next cycle in IDLE with all outputs 0 and no response.
- 65536 back-to-back transactions. Required: `txn_count` wraps to 0.

Source files
------------

// File: rtl/design04_pkg.sv
// Shared sizes and state encoding for the mkDesign_04 requester-side client.
package design04_pkg;

  localparam int D04_WIDTH = 8;
  localparam int D04_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_RES,
    S_CHECK,
    S_RESP
  } d04_state_t;

endpackage

// File: rtl/design04_client.sv
// Sequences start -> result -> check on mkDesign_04 for one host request at a time,
// honouring every RDY_* guard with a bounded wait, and returns result/check/timeout.
module design04_client
  import design04_pkg::*;
#(
  parameter int WIDTH   = D04_WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 req_valid,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [WIDTH-1:0]     rsp_result,
  output logic [WIDTH-1:0]     rsp_check,
  output logic                 rsp_timeout,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     start_a,
  output logic [WIDTH-1:0]     start_b,
  output logic                 EN_start,
  input  logic                 RDY_start,
  input  logic [WIDTH-1:0]     result,
  input  logic                 RDY_result,
  output logic                 EN_check,
  input  logic [WIDTH-1:0]     check,
  input  logic                 RDY_check,
  output logic [D04_CNT_W-1:0] txn_count
);

  localparam logic [D04_CNT_W-1:0] TIMEOUT_C = D04_CNT_W'(TIMEOUT);

  d04_state_t           state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]     res_q, res_d, chk_q, chk_d;
  logic                 to_q, to_d;
  logic [D04_CNT_W-1:0] cnt_q, cnt_d;
  logic [D04_CNT_W-1:0] txn_q, txn_d;
  logic                 expired;

  assign expired = (cnt_q == TIMEOUT_C);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned
    // (which would infer a latch); the default cnt_d of 0 also clears the wait
    // counter on every state change, since only "stay and wait" paths override it.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    chk_d   = chk_q;
    to_d    = to_q;
    txn_d   = txn_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          res_d   = '0;
          chk_d   = '0;
          to_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (RDY_start) begin
          state_d = S_WAIT_RES;
        end else if (expired) begin
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + D04_CNT_W'(1);
        end
      end
      S_WAIT_RES: begin
        if (RDY_result) begin
          res_d   = result;
          state_d = S_CHECK;
        end else if (expired) begin
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + D04_CNT_W'(1);
        end
      end
      S_CHECK: begin
        // check is an actionvalue: its value is valid only in the EN_check cycle.
        if (RDY_check) begin
          chk_d   = check;
          state_d = S_RESP;
        end else if (expired) begin
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + D04_CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          txn_d   = txn_q + D04_CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; all of these are plain flops, so all are cleared on reset.
    if (!RST_N) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      chk_q   <= '0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      chk_q   <= chk_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      txn_q   <= txn_d;
    end
  end

  // Handshake outputs are also gated by RST_N so a reset cycle never fires a
  // device method or offers/accepts a host transfer.
  assign EN_start    = RST_N && (state_q == S_START) && RDY_start;
  assign EN_check    = RST_N && (state_q == S_CHECK) && RDY_check;
  assign req_ready   = RST_N && (state_q == S_IDLE);
  assign rsp_valid   = RST_N && (state_q == S_RESP);
  assign start_a     = (state_q == S_START) ? a_q : '0;
  assign start_b     = (state_q == S_START) ? b_q : '0;
  assign rsp_result  = res_q;
  assign rsp_check   = chk_q;
  assign rsp_timeout = to_q;
  assign txn_count   = txn_q;

endmodule

// File: tb/tb_design04_client.sv
// Self-checking bench for design04_client: randomized guard stalls and host
// back-pressure checked cycle by cycle against a phase-timeline reference model.
module tb_design04_client;

  localparam int W       = 8;
  localparam int T_MAIN  = 6;
  localparam int T_SHORT = 4;

  logic         CLK;
  logic         RST_N;
  logic         req_valid, req_valid4;
  logic [W-1:0] req_a, req_b;
  logic         rsp_ready, rsp_ready4;
  logic         RDY_start, RDY_result, RDY_check;
  logic [W-1:0] result, check;

  logic         req_ready, rsp_valid, rsp_timeout, EN_start, EN_check;
  logic [W-1:0] rsp_result, rsp_check, start_a, start_b;
  logic [15:0]  txn_count;

  logic         req_ready4, rsp_valid4, rsp_timeout4, EN_start4, EN_check4;
  logic [W-1:0] rsp_result4, rsp_check4, start_a4, start_b4;
  logic [15:0]  txn_count4;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_txn;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  design04_client #(.WIDTH(W), .TIMEOUT(T_MAIN)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_check(rsp_check),
    .rsp_timeout(rsp_timeout), .rsp_ready(rsp_ready),
    .start_a(start_a), .start_b(start_b), .EN_start(EN_start), .RDY_start(RDY_start),
    .result(result), .RDY_result(RDY_result),
    .EN_check(EN_check), .check(check), .RDY_check(RDY_check),
    .txn_count(txn_count)
  );

  design04_client #(.WIDTH(W), .TIMEOUT(T_SHORT)) dut4 (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid4), .req_a(req_a), .req_b(req_b), .req_ready(req_ready4),
    .rsp_valid(rsp_valid4), .rsp_result(rsp_result4), .rsp_check(rsp_check4),
    .rsp_timeout(rsp_timeout4), .rsp_ready(rsp_ready4),
    .start_a(start_a4), .start_b(start_b4), .EN_start(EN_start4), .RDY_start(RDY_start),
    .result(result), .RDY_result(RDY_result),
    .EN_check(EN_check4), .check(check), .RDY_check(RDY_check),
    .txn_count(txn_count4)
  );

  // One transaction on dut. The model turns the guard stall lengths (s1/s2/s3,
  // in low cycles before the guard rises; > T_MAIN means it never rises in time)
  // and the response hold r into the cycle of every expected event.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic [W-1:0] chk,
                         input int s1, input int s2, input int s3, input int r);
    int c_en_s, c_en_c, c_resp, c_done, s_end, w0, w_end, k0, k_end;
    logic e_to;
    logic [W-1:0] e_res, e_chk;
    c_en_s = -1; c_en_c = -1;
    w0 = -1; w_end = -2; k0 = -1; k_end = -2;
    e_to = 1'b1; e_res = '0; e_chk = '0;
    s_end  = 1 + ((s1 <= T_MAIN) ? s1 : T_MAIN);
    c_resp = s_end + 1;
    if (s1 <= T_MAIN) begin
      c_en_s = s_end;
      w0     = s_end + 1;
      w_end  = w0 + ((s2 <= T_MAIN) ? s2 : T_MAIN);
      c_resp = w_end + 1;
      if (s2 <= T_MAIN) begin
        e_res  = res;
        k0     = w_end + 1;
        k_end  = k0 + ((s3 <= T_MAIN) ? s3 : T_MAIN);
        c_resp = k_end + 1;
        if (s3 <= T_MAIN) begin
          c_en_c = k_end;
          e_chk  = chk;
          e_to   = 1'b0;
        end
      end
    end
    c_done = c_resp + r;

    for (int cyc = 0; cyc <= c_done; cyc++) begin
      logic in_s, in_w, in_k, in_r;
      logic [W-1:0] e_sa, e_sb;
      @(negedge CLK);
      in_s = (cyc >= 1) && (cyc <= s_end);
      in_w = (cyc >= w0) && (cyc <= w_end);
      in_k = (cyc >= k0) && (cyc <= k_end);
      in_r = (cyc >= c_resp);
      req_valid4 = 1'b0;
      req_valid  = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      req_a      = (cyc == 0) ? a : W'($urandom);
      req_b      = (cyc == 0) ? b : W'($urandom);
      RDY_start  = in_s ? (cyc - 1 >= s1) : 1'($urandom_range(0, 1));
      RDY_result = in_w ? (cyc - w0 >= s2) : 1'($urandom_range(0, 1));
      result     = (in_w && RDY_result) ? res : W'($urandom);
      RDY_check  = in_k ? (cyc - k0 >= s3) : 1'($urandom_range(0, 1));
      check      = (in_k && RDY_check) ? chk : W'($urandom);
      rsp_ready  = in_r ? (cyc - c_resp >= r) : 1'($urandom_range(0, 1));
      #1;
      e_sa = in_s ? a : '0;
      e_sb = in_s ? b : '0;
      n_tests++;
      if (req_ready !== (cyc == 0)) begin
        n_fail++; $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, cyc == 0);
      end
      n_tests++;
      if (EN_start !== (cyc == c_en_s)) begin
        n_fail++; $display("FAIL EN_start cyc=%0d got=%b exp=%b", cyc, EN_start, cyc == c_en_s);
      end
      n_tests++;
      if (EN_check !== (cyc == c_en_c)) begin
        n_fail++; $display("FAIL EN_check cyc=%0d got=%b exp=%b", cyc, EN_check, cyc == c_en_c);
      end
      n_tests++;
      if ({start_a, start_b} !== {e_sa, e_sb}) begin
        n_fail++; $display("FAIL start_ab cyc=%0d got=%h/%h exp=%h/%h", cyc, start_a, start_b, e_sa, e_sb);
      end
      n_tests++;
      if (rsp_valid !== in_r) begin
        n_fail++; $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, in_r);
      end
      if (in_r) begin
        n_tests++;
        if ({rsp_timeout, rsp_result, rsp_check} !== {e_to, e_res, e_chk}) begin
          n_fail++;
          $display("FAIL rsp_fields cyc=%0d got to=%b res=%h chk=%h exp to=%b res=%h chk=%h",
                   cyc, rsp_timeout, rsp_result, rsp_check, e_to, e_res, e_chk);
        end
      end
      n_tests++;
      if (txn_count !== exp_txn) begin
        n_fail++; $display("FAIL txn_count cyc=%0d got=%h exp=%h", cyc, txn_count, exp_txn);
      end
    end
    exp_txn = exp_txn + 16'd1;
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    req_valid = 1'b0; req_valid4 = 1'b0; rsp_ready = 1'b0; rsp_ready4 = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; req_valid = 1'b0; req_valid4 = 1'b0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0; rsp_ready4 = 1'b0; RDY_start = 1'b1; RDY_result = 1'b1;
    RDY_check = 1'b1; result = '0; check = '0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    #1;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_timeout, EN_start, EN_check} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=10000",
                         {req_ready, rsp_valid, rsp_timeout, EN_start, EN_check});
    end
    n_tests++;
    if ({rsp_result, rsp_check, start_a, start_b, txn_count} !== 48'h0) begin
      n_fail++; $display("FAIL reset_data got=%h exp=0",
                         {rsp_result, rsp_check, start_a, start_b, txn_count});
    end
    n_tests++;
    if ({req_ready4, rsp_valid4, txn_count4} !== {2'b10, 16'h0}) begin
      n_fail++; $display("FAIL reset_dut4 got=%h exp=%h", {req_ready4, rsp_valid4, txn_count4}, {2'b10, 16'h0});
    end
    exp_txn = 16'h0;
  endtask

  task automatic test_basic();
    run_txn(8'h12, 8'h34, 8'h46, 8'hA5, 0, 0, 0, 0);
    idle_cycle();
    n_tests++;
    if (txn_count !== 16'd1) begin
      n_fail++; $display("FAIL basic_txn_count got=%h exp=0001", txn_count);
    end
  endtask

  task automatic test_start_stall();
    run_txn(8'h12, 8'h34, 8'h77, 8'h88, 5, 0, 0, 0);
  endtask

  task automatic test_rsp_hold();
    run_txn(8'h3C, 8'hC3, 8'h99, 8'h11, 1, 2, 1, 10);
    run_txn(8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 0, 0);
  endtask

  task automatic test_timeout_boundary();
    run_txn(8'hA1, 8'hB2, 8'hC3, 8'hD4, T_MAIN, T_MAIN, T_MAIN, 0);
    run_txn(8'hA1, 8'hB2, 8'hC3, 8'hD4, T_MAIN + 1, 0, 0, 1);
    run_txn(8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, T_MAIN + 1, 0, 0);
    run_txn(8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 0, T_MAIN + 1, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      run_txn(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
              $urandom_range(0, T_MAIN + 2), $urandom_range(0, T_MAIN + 2),
              $urandom_range(0, T_MAIN + 2), $urandom_range(0, 3));
    end
  endtask

  // RDY_result stuck low on the TIMEOUT=4 instance: START at cycle 1, WAIT_RES
  // cycles 2..6, timed-out response from cycle 7, handshake at cycle 9.
  task automatic test_timeout_stuck();
    for (int cyc = 0; cyc <= 10; cyc++) begin
      @(negedge CLK);
      req_valid  = 1'b0;
      req_valid4 = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      req_a      = 8'h12;
      req_b      = 8'h34;
      RDY_start  = 1'b1;
      RDY_result = 1'b0;
      RDY_check  = 1'b1;
      result     = W'($urandom_range(1, 255));
      check      = W'($urandom_range(1, 255));
      rsp_ready4 = (cyc == 9);
      if (cyc == 10) req_valid4 = 1'b0;
      #1;
      n_tests++;
      if ({EN_start4, EN_check4} !== {cyc == 1, 1'b0}) begin
        n_fail++; $display("FAIL stuck_en cyc=%0d got=%b%b exp=%b0", cyc, EN_start4, EN_check4, cyc == 1);
      end
      n_tests++;
      if (rsp_valid4 !== (cyc >= 7 && cyc <= 9)) begin
        n_fail++; $display("FAIL stuck_rsp_valid cyc=%0d got=%b", cyc, rsp_valid4);
      end
      if (cyc >= 7 && cyc <= 9) begin
        n_tests++;
        if ({rsp_timeout4, rsp_result4, rsp_check4} !== {1'b1, 16'h0}) begin
          n_fail++; $display("FAIL stuck_fields cyc=%0d got to=%b res=%h chk=%h exp to=1 res=00 chk=00",
                             cyc, rsp_timeout4, rsp_result4, rsp_check4);
        end
      end
      n_tests++;
      if (txn_count4 !== ((cyc == 10) ? 16'd1 : 16'd0)) begin
        n_fail++; $display("FAIL stuck_txn cyc=%0d got=%h", cyc, txn_count4);
      end
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    // Reset landing in START with RDY_start high must not fire EN_start.
    @(negedge CLK);
    req_valid = 1'b1; req_a = 8'h5A; req_b = 8'hC3; RDY_start = 1'b1; RDY_result = 1'b0;
    @(negedge CLK);
    req_valid = 1'b0; RST_N = 1'b0;
    #1;
    n_tests++;
    if (EN_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_start_en got=%b exp=0", EN_start);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    // Now reset during WAIT_RES: accept (0), START/EN (1), WAIT_RES (2,3), reset at 3.
    @(negedge CLK);
    req_valid = 1'b1; req_a = 8'h5A; req_b = 8'hC3;
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    n_tests++;
    if ({EN_start, EN_check, rsp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_cycle_en got=%b exp=000", {EN_start, EN_check, rsp_valid});
    end
    @(negedge CLK);
    RST_N = 1'b1; RDY_result = 1'b1; RDY_check = 1'b1; rsp_ready = 1'b1;
    #1;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_timeout, EN_start, EN_check} !== 5'b10000 ||
        {rsp_result, rsp_check, start_a, start_b, txn_count} !== 48'h0) begin
      n_fail++; $display("FAIL reset_mid_state got=%b/%h exp=10000/0",
                         {req_ready, rsp_valid, rsp_timeout, EN_start, EN_check},
                         {rsp_result, rsp_check, start_a, start_b, txn_count});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      #1;
      n_tests++;
      if ({rsp_valid, EN_check, req_ready} !== 3'b001) begin
        n_fail++; $display("FAIL reset_mid_norsp i=%0d got=%b exp=001", i, {rsp_valid, EN_check, req_ready});
      end
    end
    exp_txn = 16'h0;
  endtask

  // A full 65536-transaction run is far beyond the cycle budget, so the counter
  // is preset near its top and the last few transactions cross the wrap.
  task automatic test_wrap();
    @(negedge CLK);
    req_valid = 1'b0; rsp_ready = 1'b0;
    force dut.txn_q = 16'hFFFE;
    @(negedge CLK);
    release dut.txn_q;
    exp_txn = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      run_txn(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 0, 0, 0, 0);
    end
    idle_cycle();
    n_tests++;
    if (txn_count !== 16'h0001) begin
      n_fail++; $display("FAIL wrap_txn_count got=%h exp=0001", txn_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_stall();
    test_rsp_hold();
    test_timeout_boundary();
    test_random();
    test_timeout_stuck();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
